// File: rtl/pipeline_stream_sink_if.sv
// Dual-lane (data, valid) stream from the pipeline top into the sink,
// with the registered stall request flowing back upstream.
interface pipeline_stream_sink_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data_1;
    logic              in_valid_1;
    logic [DATA_W-1:0] in_data_2;
    logic              in_valid_2;
    logic              stall_out;

    modport master (
        output in_data_1, in_valid_1, in_data_2, in_valid_2,
        input  stall_out
    );

    modport slave (
        input  in_data_1, in_valid_1, in_data_2, in_valid_2,
        output stall_out
    );
endinterface

// File: rtl/pipeline_stream_sink.sv
// Receiving end of the dual-pipeline output: per-lane FIFOs drained at a throttled rate.
// Optional sequence checker enabled by defining SINK_SEQ_CHECK_EN.
module pipeline_stream_sink #(
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 8,
    parameter int                STALL_MARGIN = 2,
    parameter int                DRAIN_DIV    = 4,
    parameter logic [DATA_W-1:0] EXP_INIT_1   = '0,
    parameter logic [DATA_W-1:0] EXP_INIT_2   = '0,
    parameter logic [DATA_W-1:0] EXP_STEP     = 1,
    parameter int                CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_stream_sink_if.slave   stream_if,
    output logic [31:0]             rx_count_1_o,
    output logic [31:0]             rx_count_2_o,
    output logic [CNT_W-1:0]        err_count_1_o,
    output logic [CNT_W-1:0]        err_count_2_o,
    output logic                    overflow_1_o,
    output logic                    overflow_2_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    logic [DATA_W-1:0] lane_data [2];
    logic [1:0]        lane_valid;
    logic [1:0]        near_full;
    logic [31:0]       rx_cnt  [2];
    logic [CNT_W-1:0]  err_cnt [2];
    logic [1:0]        ovf;

    assign lane_data[0] = stream_if.in_data_1;
    assign lane_data[1] = stream_if.in_data_2;
    assign lane_valid   = {stream_if.in_valid_2, stream_if.in_valid_1};

    logic [DIV_W-1:0] div_q, div_d;
    logic             drain_tick;

    assign drain_tick = (div_q == DIV_W'(DRAIN_DIV - 1));
    assign div_d      = drain_tick ? '0 : div_q + 1'b1;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [OCC_W-1:0]  occ_q, occ_d;
        logic [31:0]       rx_q;
        logic              ovf_q;
        logic              empty, full, pop, push, drop;
        logic [DATA_W-1:0] popped;

        assign empty  = (occ_q == '0);
        assign full   = (occ_q == OCC_W'(DEPTH));
        assign pop    = drain_tick & ~empty;
        // A pop on the same cycle frees the slot, so a full FIFO still accepts.
        assign push   = lane_valid[l] & (~full | pop);
        assign drop   = lane_valid[l] & full & ~pop;
        assign popped = mem_q[rd_ptr_q];

        always_comb begin
            occ_d = occ_q;
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end

        assign near_full[l] = (OCC_W'(DEPTH) - occ_d) <= OCC_W'(STALL_MARGIN);

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= lane_data[l];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                rx_q     <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    rx_q     <= rx_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                occ_q <= occ_d;
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign rx_cnt[l] = rx_q;
        assign ovf[l]    = ovf_q;

`ifdef SINK_SEQ_CHECK_EN
        localparam logic [DATA_W-1:0] EXP_INIT = (l == 0) ? EXP_INIT_1 : EXP_INIT_2;
        logic [DATA_W-1:0] exp_q;
        logic [CNT_W-1:0]  err_q;

        // Expected value always follows the popped word so a gap costs one error only.
        always_ff @(posedge clk) begin
            if (reset) begin
                exp_q <= EXP_INIT;
                err_q <= '0;
            end else if (pop) begin
                if ((popped != exp_q) && (err_q != '1)) begin
                    err_q <= err_q + 1'b1;
                end
                exp_q <= popped + EXP_STEP;
            end
        end

        assign err_cnt[l] = err_q;
`else
        logic unused_popped;
        assign unused_popped = ^popped;
        assign err_cnt[l]    = '0;
`endif
    end

`ifndef SINK_SEQ_CHECK_EN
    logic unused_exp;
    assign unused_exp = ^{EXP_INIT_1, EXP_INIT_2, EXP_STEP};
`endif

    logic stall_q, stall_d;

    assign stall_d = |near_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            stall_q <= stall_d;
        end
    end

    assign stream_if.stall_out = stall_q;
    assign rx_count_1_o        = rx_cnt[0];
    assign rx_count_2_o        = rx_cnt[1];
    assign err_count_1_o       = err_cnt[0];
    assign err_count_2_o       = err_cnt[1];
    assign overflow_1_o        = ovf[0];
    assign overflow_2_o        = ovf[1];
endmodule
